// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: requests issue the cycle after credit frees; a response is visible on dec_* one cycle after it arrives.
// Backpressure: imem_req_valid is held low once queued plus in-flight reaches DEPTH; dec_ready low stalls the head; responses cannot be stalled.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]        imem_rsp_data,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [INST_WIDTH-1:0]        dec_inst,
  output logic [ADDR_WIDTH-1:0]        dec_pc,
  output logic [ADDR_WIDTH-1:0]        dec_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         rsp_err
);

  localparam int unsigned           CW       = $clog2(DEPTH + 1);
  localparam int unsigned           PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INST_WIDTH / 8);
  localparam logic [PW-1:0]         LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]           CREDITS  = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                storage_q [DEPTH];
  entry_t                head_dat;
  entry_t                push_dat;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  rsp_drop;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both buffered entries and requests still in flight, so a push always has room.
  assign imem_req_valid = !rst && (({1'b0, occ_q} + {1'b0, outstanding_q}) < CREDITS);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (outstanding_q != '0);
  assign rsp_drop = rsp_fire & (drop_cnt_q != '0);
  assign push     = rsp_fire & ~rsp_drop & ~redirect_valid;
  assign pop      = dec_valid & dec_ready & ~redirect_valid;

  assign head_dat    = storage_q[rd_ptr_q];
  assign push_dat    = '{inst: imem_rsp_data, pc: rsp_pc_q};
  assign dec_valid   = (occ_q != '0);
  assign dec_inst    = head_dat.inst;
  assign dec_pc      = head_dat.pc;
  assign dec_next_pc = head_dat.pc + PC_STEP;
  assign occupancy   = occ_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    rsp_err_d     = rsp_err_q | (imem_rsp_valid & (outstanding_q == '0));

    if (redirect_valid) begin
      // Everything still owed by memory after this edge belongs to the old path.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      storage_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed checks of fetch_queue plus a randomised run against a memory and decode-stream model.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_next_pc;
  logic [2:0]  occupancy;
  logic        rsp_err;

  fetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_next_pc(dec_next_pc),
    .occupancy(occupancy), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Knobs read by the driver at every falling edge.
  int          cfg_req_mode = 0;   // 0: budget-limited, 1: always ready, 2: random
  int          req_budget   = 0;
  int          cfg_dec_mode = 0;   // 0: never, 1: always, 2: random
  int          cfg_lat      = 1;
  bit          cfg_lat_rand = 1'b0;
  bit          cfg_rand_redir = 1'b0;
  int          redir_seq = 0, redir_done = 0;
  logic [31:0] redir_addr = '0;
  int          inj_seq = 0, inj_done = 0;

  int          cyc = 0;
  int          req_cnt = 0;
  int          dec_cnt = 0;
  logic [31:0] req_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req_pc = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model, decode sink and stream scoreboard; acts on falling edges for the next rising edge.
  task automatic run_driver();
    bit          redir;
    logic [31:0] nxt;
    int          lat, due;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        last_due       = 0;
        exp_pc         = RST_PC;
        exp_req_pc     = RST_PC;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redir_done     = redir_seq;
        inj_done       = inj_seq;
      end else begin
        n_checks++;
        if (int'(occupancy) + pend_addr.size() > 4 || int'(occupancy) > 4) begin
          $display("FAIL credit_limit: occupancy=%0d in_flight=%0d, required sum <= 4", occupancy, pend_addr.size());
        end else n_pass++;

        case (cfg_req_mode)
          0:       imem_req_ready = (req_cnt < req_budget);
          1:       imem_req_ready = 1'b1;
          default: imem_req_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (cfg_dec_mode)
          0:       dec_ready = 1'b0;
          1:       dec_ready = 1'b1;
          default: dec_ready = ($urandom_range(0, 2) != 0);
        endcase

        if (inj_seq != inj_done) begin
          inj_done       = inj_seq;
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEAD_0BAD;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end

        redir = 1'b0;
        nxt   = '0;
        if (redir_seq != redir_done) begin
          redir_done = redir_seq;
          redir = 1'b1;
          nxt   = redir_addr;
        end else if (cfg_rand_redir && $urandom_range(0, 24) == 0) begin
          redir = 1'b1;
          nxt   = $urandom() & 32'hFFFF_FFFC;
        end
        redirect_valid = redir;
        redirect_pc    = nxt;

        if (imem_req_valid && imem_req_ready) begin
          n_checks++;
          if (imem_req_addr !== exp_req_pc) begin
            $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_req_pc);
          end else n_pass++;
          req_log.push_back(imem_req_addr);
          lat = cfg_lat_rand ? $urandom_range(1, 5) : cfg_lat;
          due = cyc + 1 + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(due);
          exp_req_pc = exp_req_pc + 32'd4;
          req_cnt++;
        end

        if (dec_valid && dec_ready) begin
          n_checks++;
          if (dec_pc !== exp_pc || dec_inst !== mem_word(exp_pc) || dec_next_pc !== exp_pc + 32'd4) begin
            $display("FAIL dec_stream: got pc=%h inst=%h next=%h, required pc=%h inst=%h next=%h",
                     dec_pc, dec_inst, dec_next_pc, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
          end else n_pass++;
          exp_pc = exp_pc + 32'd4;
          dec_cnt++;
        end

        if (redir) begin
          exp_pc     = nxt;
          exp_req_pc = nxt;
        end
      end
    end
  endtask

  // Stops new requests, empties the queue and waits for memory to go idle.
  task automatic drain(output bit ok);
    int n = 0;
    cfg_rand_redir = 1'b0;
    cfg_req_mode   = 0;
    req_budget     = req_cnt;
    cfg_dec_mode   = 1;
    @(posedge clk); #2;
    while ((occupancy != 0 || pend_addr.size() != 0) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (occupancy == 0 && pend_addr.size() == 0);
    cfg_dec_mode = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
      $display("FAIL reset_valids: req_valid=%b dec_valid=%b, required 0 0", imem_req_valid, dec_valid);
    end else n_pass++;
    n_checks++;
    if (occupancy !== 3'd0 || rsp_err !== 1'b0) begin
      $display("FAIL reset_state: occupancy=%0d rsp_err=%b, required 0 0", occupancy, rsp_err);
    end else n_pass++;
    rst = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      $display("FAIL reset_first_req: valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end else n_pass++;
  endtask

  task automatic test_fill();
    cfg_lat      = 1;
    cfg_dec_mode = 0;
    cfg_req_mode = 1;
    repeat (12) @(posedge clk);
    #2;
    n_checks++;
    if (req_cnt != 4) begin
      $display("FAIL fill_req_count: got %0d, required 4", req_cnt);
    end else n_pass++;
    n_checks++;
    if (req_log.size() < 4 || req_log[0] !== 32'h100 || req_log[1] !== 32'h104 ||
        req_log[2] !== 32'h108 || req_log[3] !== 32'h10C) begin
      $display("FAIL fill_req_addrs: got %0d requests, required 100 104 108 10c", req_log.size());
    end else n_pass++;
    n_checks++;
    if (imem_req_valid !== 1'b0 || occupancy !== 3'd4) begin
      $display("FAIL fill_credit: req_valid=%b occupancy=%0d, required 0 4", imem_req_valid, occupancy);
    end else n_pass++;
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_next_pc !== 32'h104 || dec_inst !== mem_word(32'h100)) begin
      $display("FAIL fill_head: valid=%b pc=%h next=%h inst=%h, required 1 100 104 %h",
               dec_valid, dec_pc, dec_next_pc, dec_inst, mem_word(32'h100));
    end else n_pass++;
  endtask

  task automatic test_stream();
    int c0;
    cfg_dec_mode = 1;
    repeat (6) @(posedge clk);
    #2;
    c0 = dec_cnt;
    repeat (16) @(posedge clk);
    #2;
    n_checks++;
    if (dec_cnt - c0 != 16) begin
      $display("FAIL stream_rate: got %0d pops in 16 cycles, required 16", dec_cnt - c0);
    end else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    int n;
    drain(ok);
    n_checks++;
    if (!ok) $display("FAIL inflight_drain: occupancy=%0d in_flight=%0d, required 0 0", occupancy, pend_addr.size());
    else n_pass++;
    cfg_lat    = 3;
    req_budget = req_cnt + 3;
    repeat (3) @(posedge clk);
    #2;
    redir_addr = 32'h2000;
    redir_seq++;
    @(posedge clk); #2;
    n_checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_req_addr !== 32'h2000) begin
      $display("FAIL inflight_flush: occupancy=%0d dec_valid=%b req_addr=%h, required 0 0 2000",
               occupancy, dec_valid, imem_req_addr);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (occupancy !== 3'd0) $display("FAIL inflight_drop: cycle %0d occupancy=%0d, required 0", i, occupancy);
      else n_pass++;
    end
    req_budget = req_cnt + 1;
    n = 0;
    while (!dec_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 || dec_inst !== mem_word(32'h2000) || occupancy !== 3'd1) begin
      $display("FAIL inflight_refill: valid=%b pc=%h occupancy=%0d, required 1 2000 1", dec_valid, dec_pc, occupancy);
    end else n_pass++;
  endtask

  task automatic test_redirect_coincide();
    bit ok;
    drain(ok);
    n_checks++;
    if (!ok) $display("FAIL coincide_drain: occupancy=%0d in_flight=%0d, required 0 0", occupancy, pend_addr.size());
    else n_pass++;
    cfg_lat      = 2;
    cfg_req_mode = 1;
    repeat (2) @(posedge clk);
    #2;
    redir_addr = 32'h3000;
    redir_seq++;
    @(posedge clk); #2;
    n_checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_req_addr !== 32'h3000) begin
      $display("FAIL coincide_flush: occupancy=%0d dec_valid=%b req_addr=%h, required 0 0 3000",
               occupancy, dec_valid, imem_req_addr);
    end else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (occupancy !== 3'd0) $display("FAIL coincide_drop: cycle %0d occupancy=%0d, required 0", i, occupancy);
      else n_pass++;
    end
    @(posedge clk); #2;
    n_checks++;
    if (occupancy !== 3'd1 || dec_pc !== 32'h3000 || dec_inst !== mem_word(32'h3000)) begin
      $display("FAIL coincide_first: occupancy=%0d pc=%h inst=%h, required 1 3000 %h",
               occupancy, dec_pc, dec_inst, mem_word(32'h3000));
    end else n_pass++;
  endtask

  task automatic test_stress();
    int d0;
    d0             = dec_cnt;
    cfg_req_mode   = 2;
    cfg_dec_mode   = 2;
    cfg_lat_rand   = 1'b1;
    cfg_rand_redir = 1'b1;
    repeat (3000) @(posedge clk);
    #2;
    cfg_rand_redir = 1'b0;
    n_checks++;
    if (rsp_err !== 1'b0) $display("FAIL stress_rsp_err: got %b, required 0", rsp_err);
    else n_pass++;
    n_checks++;
    if (dec_cnt - d0 < 200) $display("FAIL stress_progress: got %0d pops, required at least 200", dec_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    int idx, n;
    drain(ok);
    n_checks++;
    if (!ok) $display("FAIL wrap_drain: occupancy=%0d in_flight=%0d, required 0 0", occupancy, pend_addr.size());
    else n_pass++;
    cfg_lat_rand = 1'b0;
    cfg_lat      = 1;
    redir_addr   = 32'hFFFF_FFFC;
    redir_seq++;
    repeat (2) @(posedge clk);
    #2;
    idx        = req_log.size();
    req_budget = req_cnt + 2;
    n = 0;
    while (occupancy != 3'd2 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    n_checks++;
    if (req_log.size() < idx + 2 || req_log[idx] !== 32'hFFFF_FFFC || req_log[idx+1] !== 32'h0) begin
      $display("FAIL wrap_req_addrs: got %0d new requests, required fffffffc then 00000000", req_log.size() - idx);
    end else n_pass++;
    n_checks++;
    if (occupancy !== 3'd2 || dec_pc !== 32'hFFFF_FFFC || dec_next_pc !== 32'h0 || dec_inst !== mem_word(32'hFFFF_FFFC)) begin
      $display("FAIL wrap_head: occupancy=%0d pc=%h next=%h, required 2 fffffffc 00000000", occupancy, dec_pc, dec_next_pc);
    end else n_pass++;
  endtask

  task automatic test_spurious();
    inj_seq++;
    @(posedge clk); #2;
    n_checks++;
    if (rsp_err !== 1'b1 || occupancy !== 3'd2 || dec_pc !== 32'hFFFF_FFFC) begin
      $display("FAIL spurious_flag: rsp_err=%b occupancy=%0d pc=%h, required 1 2 fffffffc", rsp_err, occupancy, dec_pc);
    end else n_pass++;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (rsp_err !== 1'b1) $display("FAIL spurious_sticky: got %b, required 1", rsp_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int idx, n;
    cfg_lat      = 2;
    cfg_req_mode = 1;
    cfg_dec_mode = 1;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || rsp_err !== 1'b0) begin
      $display("FAIL midreset_clear: occupancy=%0d dec_valid=%b req_valid=%b rsp_err=%b, required 0 0 0 0",
               occupancy, dec_valid, imem_req_valid, rsp_err);
    end else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    idx = req_log.size();
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      $display("FAIL midreset_restart: valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end else n_pass++;
    n = 0;
    while (!dec_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    n_checks++;
    if (req_log.size() <= idx || req_log[idx] !== RST_PC || dec_valid !== 1'b1 || dec_pc !== RST_PC) begin
      $display("FAIL midreset_first: dec_valid=%b dec_pc=%h, required 1 %h", dec_valid, dec_pc, RST_PC);
    end else n_pass++;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dec_ready      = 1'b0;
    fork
      run_driver();
    join_none
    test_reset();
    test_fill();
    test_stream();
    test_redirect_inflight();
    test_redirect_coincide();
    test_stress();
    test_pc_wrap();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded 1 ms, required completion");
    $fatal(1, "timeout");
  end

endmodule
